// File: rtl/bayer_demosaic_5x5_if.sv
// bayer_demosaic_5x5_if: window-in / RGB-out bus for the demosaic stage
interface bayer_demosaic_5x5_if #(parameter int DW = 8);
  logic in_valid;
  logic [3:0] bayer_state;
  logic [25*DW-1:0] win;
  logic bypass;
  logic out_valid;
  logic [DW-1:0] r_out;
  logic [DW-1:0] g_out;
  logic [DW-1:0] b_out;
  logic phase_err;
  modport master(output in_valid, bayer_state, win, bypass,
                 input out_valid, r_out, g_out, b_out, phase_err);
  modport slave(input in_valid, bayer_state, win, bypass,
                output out_valid, r_out, g_out, b_out, phase_err);
endinterface

// File: rtl/bayer_demosaic_5x5.sv
// bayer_demosaic_5x5: 3-stage Malvar-He-Cutler 5x5 Bayer-to-RGB interpolator
module bayer_demosaic_5x5 #(parameter int DW = 8) (
  input logic clk,
  input logic rst_n,
  bayer_demosaic_5x5_if.slave bus
);
  localparam int NW = DW + 6;
  logic [DW-1:0] w [1:5][1:5];
  for (genvar r = 1; r <= 5; r++) begin : g_row
    for (genvar c = 1; c <= 5; c++) begin : g_col
      assign w[r][c] = bus.win[(5*(r-1)+(c-1))*DW +: DW];
    end
  end
  logic [DW:0] h1, v1, h2, v2;
  logic [DW+1:0] a, d;
  always_comb begin
    h1 = (DW+1)'(w[3][2]) + (DW+1)'(w[3][4]);
    v1 = (DW+1)'(w[2][3]) + (DW+1)'(w[4][3]);
    h2 = (DW+1)'(w[3][1]) + (DW+1)'(w[3][5]);
    v2 = (DW+1)'(w[1][3]) + (DW+1)'(w[5][3]);
    a = (DW+2)'(h1) + (DW+2)'(v1);
    d = (DW+2)'(w[2][2]) + (DW+2)'(w[2][4]) + (DW+2)'(w[4][2]) + (DW+2)'(w[4][4]);
  end
  logic [DW-1:0] s1_c;
  logic [DW:0] s1_h1, s1_v1, s1_h2, s1_v2;
  logic [DW+1:0] s1_a, s1_d;
  logic [3:0] s1_ph;
  logic s1_byp, s1_vld;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_c <= '0;
      s1_h1 <= '0;
      s1_v1 <= '0;
      s1_h2 <= '0;
      s1_v2 <= '0;
      s1_a <= '0;
      s1_d <= '0;
      s1_ph <= '0;
      s1_byp <= 1'b0;
      s1_vld <= 1'b0;
    end else begin
      s1_c <= w[3][3];
      s1_h1 <= h1;
      s1_v1 <= v1;
      s1_h2 <= h2;
      s1_v2 <= v2;
      s1_a <= a;
      s1_d <= d;
      s1_ph <= bus.bayer_state;
      s1_byp <= bus.bypass;
      s1_vld <= bus.in_valid;
    end
  end
  // Numerators are 16x the interpolated value; shifts replace constant multiplies
  logic signed [NW-1:0] c_s, h1_s, v1_s, h2_s, v2_s, a_s, d_s, grb, hor, ver, opp;
  always_comb begin
    c_s = NW'(s1_c);
    h1_s = NW'(s1_h1);
    v1_s = NW'(s1_v1);
    h2_s = NW'(s1_h2);
    v2_s = NW'(s1_v2);
    a_s = NW'(s1_a);
    d_s = NW'(s1_d);
    grb = (c_s <<< 3) + (a_s <<< 2) - ((h2_s + v2_s) <<< 1);
    hor = (c_s <<< 3) + (c_s <<< 1) + (h1_s <<< 3) - (h2_s <<< 1) - (d_s <<< 1) + v2_s;
    ver = (c_s <<< 3) + (c_s <<< 1) + (v1_s <<< 3) - (v2_s <<< 1) - (d_s <<< 1) + h2_s;
    opp = (c_s <<< 3) + (c_s <<< 2) + (d_s <<< 2) - (h2_s + v2_s) - ((h2_s + v2_s) <<< 1);
  end
  logic signed [NW-1:0] s2_grb, s2_hor, s2_ver, s2_opp;
  logic [DW-1:0] s2_c;
  logic [3:0] s2_ph;
  logic s2_byp, s2_vld;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_grb <= '0;
      s2_hor <= '0;
      s2_ver <= '0;
      s2_opp <= '0;
      s2_c <= '0;
      s2_ph <= '0;
      s2_byp <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      s2_grb <= grb;
      s2_hor <= hor;
      s2_ver <= ver;
      s2_opp <= opp;
      s2_c <= s1_c;
      s2_ph <= s1_ph;
      s2_byp <= s1_byp;
      s2_vld <= s1_vld;
    end
  end
  // Round to nearest, divide by 16, then saturate into [0, 2^DW-1]
  function automatic logic [DW-1:0] norm(input logic signed [NW-1:0] n);
    logic signed [NW-1:0] t;
    t = n + $signed(NW'(8));
    t = t >>> 4;
    return t[NW-1] ? '0 : (|t[NW-2:DW] ? '1 : t[DW-1:0]);
  endfunction
  logic [DW-1:0] n_grb, n_hor, n_ver, n_opp, r_nx, g_nx, b_nx;
  logic oh, raw, pe_nx;
  always_comb begin
    n_grb = norm(s2_grb);
    n_hor = norm(s2_hor);
    n_ver = norm(s2_ver);
    n_opp = norm(s2_opp);
    oh = s2_ph inside {4'b0001, 4'b0010, 4'b0100, 4'b1000};
    raw = s2_byp | ~oh;
    pe_nx = ~s2_byp & ~oh;
    r_nx = raw ? s2_c : s2_ph[0] ? s2_c : s2_ph[1] ? n_hor : s2_ph[2] ? n_ver : n_opp;
    g_nx = raw ? s2_c : (s2_ph[0] | s2_ph[3]) ? n_grb : s2_c;
    b_nx = raw ? s2_c : s2_ph[0] ? n_opp : s2_ph[1] ? n_ver : s2_ph[2] ? n_hor : s2_c;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.r_out <= '0;
      bus.g_out <= '0;
      bus.b_out <= '0;
      bus.phase_err <= 1'b0;
    end else begin
      bus.out_valid <= s2_vld;
      bus.r_out <= r_nx;
      bus.g_out <= g_nx;
      bus.b_out <= b_nx;
      bus.phase_err <= pe_nx;
    end
  end
endmodule

// File: tb/tb_bayer_demosaic_5x5.sv
// tb_bayer_demosaic_5x5: directed-vector bench for the 5x5 demosaic pipeline
module tb_bayer_demosaic_5x5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [7:0] pix [1:5][1:5];
  bayer_demosaic_5x5_if #(.DW(8)) bus ();
  bayer_demosaic_5x5 #(.DW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  localparam logic [3:0] PR = 4'b0001, PGR = 4'b0010, PGB = 4'b0100, PB = 4'b1000;
  task automatic fill(input logic [7:0] v);
    for (int r = 1; r <= 5; r++)
      for (int c = 1; c <= 5; c++)
        pix[r][c] = v;
  endtask
  task automatic load(input logic [3:0] st, input logic byp);
    for (int r = 1; r <= 5; r++)
      for (int c = 1; c <= 5; c++)
        bus.win[(5*(r-1)+(c-1))*8 +: 8] = pix[r][c];
    bus.bayer_state = st;
    bus.bypass = byp;
  endtask
  task automatic win_r();
    fill(0);
    pix[3][3] = 200;
    pix[2][3] = 100;
    pix[4][3] = 100;
    pix[3][2] = 100;
    pix[3][4] = 100;
  endtask
  task automatic win_g();
    fill(0);
    pix[3][3] = 100;
    pix[3][2] = 200;
    pix[3][4] = 200;
  endtask
  task automatic win_b();
    fill(0);
    pix[1][3] = 255;
    pix[5][3] = 255;
    pix[3][1] = 255;
    pix[3][5] = 255;
  endtask
  // single valid cycle, returns #1 after the edge where its result appears
  task automatic issue(input logic [3:0] st, input logic byp);
    load(st, byp);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    bus.in_valid = 1'b0;
    fill(0);
    load(4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.out_valid, bus.r_out, bus.g_out, bus.b_out, bus.phase_err} !== 26'd0)
      $display("FAIL reset: got ov=%b r=%0d g=%0d b=%0d pe=%b want all 0", bus.out_valid, bus.r_out, bus.g_out, bus.b_out, bus.phase_err);
    if ({bus.out_valid, bus.r_out, bus.g_out, bus.b_out, bus.phase_err} !== 26'd0) bad++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_flat();
    logic [3:0] ph [4] = '{PR, PGR, PGB, PB};
    for (int i = 0; i < 4; i++) begin
      fill(100);
      issue(ph[i], 1'b0);
      total++;
      if ({bus.out_valid, bus.r_out, bus.g_out, bus.b_out, bus.phase_err} !== {1'b1, 8'd100, 8'd100, 8'd100, 1'b0}) begin
        bad++;
        $display("FAIL flat ph=%b: got ov=%b r=%0d g=%0d b=%0d pe=%b want 1/100/100/100/0", ph[i], bus.out_valid, bus.r_out, bus.g_out, bus.b_out, bus.phase_err);
      end
    end
  endtask
  task automatic test_latency();
    logic exp_ov [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    fill(100);
    load(PR, 1'b0);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.out_valid !== exp_ov[i]) begin
        bad++;
        $display("FAIL latency step %0d: out_valid=%b want %b", i + 1, bus.out_valid, exp_ov[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_r_phase();
    win_r();
    issue(PR, 1'b0);
    total++;
    if ({bus.out_valid, bus.r_out, bus.g_out, bus.b_out, bus.phase_err} !== {1'b1, 8'd200, 8'd200, 8'd150, 1'b0}) begin
      bad++;
      $display("FAIL r_phase: got ov=%b r=%0d g=%0d b=%0d pe=%b want 1/200/200/150/0", bus.out_valid, bus.r_out, bus.g_out, bus.b_out, bus.phase_err);
    end
  endtask
  task automatic test_green();
    win_g();
    issue(PGR, 1'b0);
    total++;
    if ({bus.out_valid, bus.r_out, bus.g_out, bus.b_out, bus.phase_err} !== {1'b1, 8'd255, 8'd100, 8'd63, 1'b0}) begin
      bad++;
      $display("FAIL gr_phase: got ov=%b r=%0d g=%0d b=%0d pe=%b want 1/255/100/63/0", bus.out_valid, bus.r_out, bus.g_out, bus.b_out, bus.phase_err);
    end
    issue(PGB, 1'b0);
    total++;
    if ({bus.out_valid, bus.r_out, bus.g_out, bus.b_out, bus.phase_err} !== {1'b1, 8'd63, 8'd100, 8'd255, 1'b0}) begin
      bad++;
      $display("FAIL gb_phase: got ov=%b r=%0d g=%0d b=%0d pe=%b want 1/63/100/255/0", bus.out_valid, bus.r_out, bus.g_out, bus.b_out, bus.phase_err);
    end
  endtask
  task automatic test_b_phase();
    win_b();
    issue(PB, 1'b0);
    total++;
    if ({bus.out_valid, bus.r_out, bus.g_out, bus.b_out, bus.phase_err} !== {1'b1, 8'd0, 8'd0, 8'd0, 1'b0}) begin
      bad++;
      $display("FAIL b_phase: got ov=%b r=%0d g=%0d b=%0d pe=%b want 1/0/0/0/0", bus.out_valid, bus.r_out, bus.g_out, bus.b_out, bus.phase_err);
    end
  endtask
  task automatic test_phase_err();
    logic [3:0] st [4] = '{4'b0011, 4'b0011, 4'b0000, PR};
    logic byp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic pe [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] cv [4] = '{8'd77, 8'd77, 8'd77, 8'd200};
    for (int i = 0; i < 4; i++) begin
      if (i == 3) win_r(); else begin fill(0); pix[3][3] = 77; pix[2][3] = 40; pix[3][4] = 90; end
      issue(st[i], byp[i]);
      total++;
      if ({bus.out_valid, bus.r_out, bus.g_out, bus.b_out, bus.phase_err} !== {1'b1, cv[i], cv[i], cv[i], pe[i]}) begin
        bad++;
        $display("FAIL raw st=%b byp=%b: got ov=%b r=%0d g=%0d b=%0d pe=%b want 1/%0d/%0d/%0d/%b", st[i], byp[i], bus.out_valid, bus.r_out, bus.g_out, bus.b_out, bus.phase_err, cv[i], cv[i], cv[i], pe[i]);
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [32:0] exp [5] = '{{1'b1, 8'd200, 8'd200, 8'd150, 1'b0}, {1'b1, 8'd255, 8'd100, 8'd63, 1'b0},
                            {1'b1, 8'd0, 8'd0, 8'd0, 1'b0}, {1'b1, 8'd77, 8'd77, 8'd77, 1'b1}, 33'd0};
    logic [32:0] got;
    win_r();
    load(PR, 1'b0);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 win_g();
    load(PGR, 1'b0);
    @(posedge clk);
    #1 win_b();
    load(PB, 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin fill(0); pix[3][3] = 77; load(4'b0011, 1'b0); end
      if (i == 1) bus.in_valid = 1'b0;
      got = {bus.out_valid, bus.r_out, bus.g_out, bus.b_out, bus.phase_err};
      total++;
      if (i < 4 ? got !== exp[i] : got[32] !== 1'b0) begin
        bad++;
        $display("FAIL b2b[%0d]: got ov=%b r=%0d g=%0d b=%0d pe=%b want ov=%b r=%0d g=%0d b=%0d pe=%b", i, got[32], got[31:24], got[23:16], got[15:8], got[0], exp[i][32], exp[i][31:24], exp[i][23:16], exp[i][15:8], exp[i][0]);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset_midstream();
    fill(100);
    load(PR, 1'b0);
    bus.in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if ({bus.out_valid, bus.r_out} !== {1'b1, 8'd100}) begin
      bad++;
      $display("FAIL midstream pre-reset: ov=%b r=%0d want 1/100", bus.out_valid, bus.r_out);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.out_valid, bus.r_out, bus.g_out, bus.b_out, bus.phase_err} !== 26'd0) begin
      bad++;
      $display("FAIL midstream async reset: got ov=%b r=%0d g=%0d b=%0d pe=%b want all 0", bus.out_valid, bus.r_out, bus.g_out, bus.b_out, bus.phase_err);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL midstream flushed %0d: out_valid=%b want 0", i, bus.out_valid);
      end
    end
    issue(PR, 1'b0);
    total++;
    if ({bus.out_valid, bus.r_out, bus.g_out, bus.b_out} !== {1'b1, 8'd100, 8'd100, 8'd100}) begin
      bad++;
      $display("FAIL midstream restart: got ov=%b r=%0d g=%0d b=%0d want 1/100/100/100", bus.out_valid, bus.r_out, bus.g_out, bus.b_out);
    end
  endtask
  initial begin
    test_reset();
    test_flat();
    test_latency();
    test_r_phase();
    test_green();
    test_b_phase();
    test_phase_err();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bayer_demosaic_5x5.md
Name: bayer_demosaic_5x5

Overview:
- Full-pipelined Bayer-to-RGB interpolator using the Malvar-He-Cutler 5x5 gradient-corrected kernels.
- Sits directly downstream of the 5x5 sliding-window stage. Consumes its 25-pixel window, the one-hot Bayer phase of the centre pixel, and the window-valid strobe.
- Produces one RGB pixel per valid window for the colour-correction / gamma stages.

Parameters:
- DW, 8, pixel width of window inputs and RGB outputs.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset.
- in_valid  input  1  window, bayer_state and bypass are valid this cycle.
- bayer_state  input  4  one-hot phase of the centre pixel: 4'b0001=R, 4'b0010=Gr (green on red row), 4'b0100=Gb (green on blue row), 4'b1000=B.
- win  input  25*DW  packed window. Pixel at row r, column c (1..5) is win[(5*(r-1)+(c-1))*DW +: DW]. Row 1 is the top (oldest) line, column 1 the leftmost; centre is r3c3.
- bypass  input  1  1 = output raw centre pixel on all three channels.
- out_valid  output  1  RGB outputs valid.
- r_out  output  DW  red.
- g_out  output  DW  green.
- b_out  output  DW  blue.
- phase_err  output  1  bayer_state was not one-hot for this pixel; qualified by out_valid.

Interface (already decided): one clock, clk; reset rst_n is asynchronous, active-low.

Behaviour:
- Reset: out_valid, phase_err, r_out, g_out, b_out = 0; all pipeline valid bits = 0.
- Reset mid-frame discards in-flight pixels; no out_valid until 3 cycles after the next in_valid.
- No stall or back-pressure. The pipeline advances every clk.
- Fixed latency: in_valid at cycle N gives out_valid at N+3. Back-to-back valid inputs give back-to-back outputs. Data registers may hold stale values when out_valid=0.

Stage 1 registers the centre and neighbour sums, plus phase, bypass and valid:
- C = r3c3
- H1 = r3c2+r3c4
- V1 = r2c3+r4c3
- A = H1+V1
- H2 = r3c1+r3c5
- V2 = r1c3+r5c3
- D = r2c2+r2c4+r4c2+r4c4

Stage 2 computes four signed numerators, scaled by 16, each DW+6 bits:
- GRB = 8C + 4A - 2(H2+V2)
- HOR = 10C + 8H1 - 2H2 - 2D + V2
- VER = 10C + 8V1 - 2V2 - 2D + H2
- OPP = 12C + 4D - 3(H2+V2)

Stage 3 normalises: each numerator becomes (num+8)>>>4 (arithmetic shift). The result clamps to 0 if negative and to 2^DW-1 if above; it is then registered.

Channel selection by phase. A channel marked C takes the centre value directly, with no arithmetic.
- R: r=C, g=GRB, b=OPP
- Gr: r=HOR, g=C, b=VER
- Gb: r=VER, g=C, b=HOR
- B: r=OPP, g=GRB, b=C

Non-one-hot bayer_state (including 0000): r=g=b=C, phase_err=1.

Bypass: r=g=b=C, phase_err=0, same 3-cycle latency. Bypass overrides the phase check.

Width check for DW=8: numerator range is -3060..+7140, which fits 14-bit signed.

Test Plan:
- Flat field, every pixel 100, each of the four phases, in_valid one cycle -> 3 cycles later out_valid=1 and r=g=b=100, phase_err=0.
- R phase, C=200, N=S=E=W=100, rest 0 -> r=200, g=200, b=150.
- Gr phase, C=100, r3c2=r3c4=200, rest 0 -> r=255 (clamped from 263), g=100, b=63. Gb phase with the same window -> r=63, g=100, b=255.
- B phase, C=0, r1c3=r5c3=r3c1=r3c5=255, rest 0 -> g=0 and r=0 (negative clamp), b=0.
- Continuous in_valid for 10 cycles, then rst_n pulsed low at cycle 5 -> all outputs 0 immediately; out_valid stays 0 until 3 cycles after the first in_valid following release.
- bayer_state=4'b0011, C=77 -> r=g=b=77 with phase_err=1. Same input with bypass=1 -> phase_err=0.
